// File: rtl/packet_assembler_pkg.sv
// Shared types and helpers for the chunk-to-packet assembler.
// Optional feature macro used by the top: PACKET_ASSEMBLER_BYPASS_EN.
package packet_assembler_pkg;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    SEND = 1'b1
  } state_e;

  function automatic int num_regs_f(input int nbits_in, input int nbits_out);
    return (nbits_out + nbits_in - 1) / nbits_in;
  endfunction

endpackage

// File: rtl/packet_assembler_ctr.sv
// Chunk counter: synchronous clear/increment with terminal count at num_regs-1.
module packet_assembler_ctr #(
  parameter int num_regs = 1,
  parameter int cnt_bits = 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                clr_i,
  input  logic                inc_i,
  output logic [cnt_bits-1:0] cnt_o,
  output logic                tc_o
);

  logic [cnt_bits-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;
  assign tc_o  = (cnt_q == cnt_bits'(num_regs - 1));

endmodule

// File: rtl/packet_assembler.sv
// Assembles nbits_in-wide chunks (first chunk most significant) into one nbits_out packet.
// Define PACKET_ASSEMBLER_BYPASS_EN to accept the next packet's first chunk while sending.
module packet_assembler
  import packet_assembler_pkg::*;
#(
  parameter int nbits_in  = 8,
  parameter int nbits_out = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 recv_val,
  output logic                 recv_rdy,
  input  logic [nbits_in-1:0]  recv_msg,
  output logic                 send_val,
  input  logic                 send_rdy,
  output logic [nbits_out-1:0] send_msg
);

  localparam int num_regs = num_regs_f(nbits_in, nbits_out);
  localparam int cnt_bits = $clog2(num_regs) + 1;
  // The most significant register only keeps the low bits of the first chunk.
  localparam int top_bits = nbits_out - nbits_in * (num_regs - 1);

  state_e                 state_q, state_d;
  logic [nbits_out-1:0]   data_q, data_d;
  logic [cnt_bits-1:0]    cnt;
  logic [cnt_bits-1:0]    wr_idx;
  logic                   tc;
  logic                   recv_xfer;
  logic                   send_xfer;

  always_comb begin
    recv_rdy = 1'b1;
    send_val = 1'b0;
    if (state_q == SEND) begin
      send_val = 1'b1;
`ifdef PACKET_ASSEMBLER_BYPASS_EN
      recv_rdy = send_rdy;
`else
      recv_rdy = 1'b0;
`endif
    end
  end

  assign recv_xfer = recv_val & recv_rdy;
  assign send_xfer = send_val & send_rdy;

  // In SEND the counter sits at 0, so a bypassed chunk is naturally chunk 0.
  packet_assembler_ctr #(
    .num_regs (num_regs),
    .cnt_bits (cnt_bits)
  ) u_ctr (
    .clk   (clk),
    .reset (reset),
    .clr_i (recv_xfer & tc),
    .inc_i (recv_xfer & ~tc),
    .cnt_o (cnt),
    .tc_o  (tc)
  );

  assign wr_idx = cnt_bits'(num_regs - 1) - cnt;

  always_comb begin
    state_d = state_q;
    if (recv_xfer && tc) begin
      state_d = SEND;
    end else if (send_xfer) begin
      state_d = FILL;
    end
  end

  always_comb begin
    data_d = data_q;
    if (recv_xfer) begin
      for (int k = 0; k < num_regs - 1; k++) begin
        if (wr_idx == cnt_bits'(k)) begin
          data_d[k*nbits_in +: nbits_in] = recv_msg;
        end
      end
      if (wr_idx == cnt_bits'(num_regs - 1)) begin
        data_d[nbits_out-1 -: top_bits] = recv_msg[top_bits-1:0];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= FILL;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

  assign send_msg = data_q;

endmodule

// File: tb/tb_packet_assembler.sv
// Self-checking bench for packet_assembler: 8->16, 8->12 and 8->8 instances, scoreboard queue.
module tb_packet_assembler;

`ifdef PACKET_ASSEMBLER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        r16_val = 1'b0, r16_rdy, s16_val, s16_rdy = 1'b0;
  logic [7:0]  r16_msg = '0;
  logic [15:0] s16_msg;
  logic        r12_val = 1'b0, r12_rdy, s12_val, s12_rdy = 1'b0;
  logic [7:0]  r12_msg = '0;
  logic [11:0] s12_msg;
  logic        r8_val = 1'b0, r8_rdy, s8_val, s8_rdy = 1'b0;
  logic [7:0]  r8_msg = '0;
  logic [7:0]  s8_msg;

  packet_assembler #(.nbits_in(8), .nbits_out(16)) u16 (
    .clk(clk), .reset(reset), .recv_val(r16_val), .recv_rdy(r16_rdy), .recv_msg(r16_msg),
    .send_val(s16_val), .send_rdy(s16_rdy), .send_msg(s16_msg));
  packet_assembler #(.nbits_in(8), .nbits_out(12)) u12 (
    .clk(clk), .reset(reset), .recv_val(r12_val), .recv_rdy(r12_rdy), .recv_msg(r12_msg),
    .send_val(s12_val), .send_rdy(s12_rdy), .send_msg(s12_msg));
  packet_assembler #(.nbits_in(8), .nbits_out(8)) u8 (
    .clk(clk), .reset(reset), .recv_val(r8_val), .recv_rdy(r8_rdy), .recv_msg(r8_msg),
    .send_val(s8_val), .send_rdy(s8_rdy), .send_msg(s8_msg));

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] exp;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chunk16(input logic [7:0] b);
    r16_val = 1'b1;
    r16_msg = b;
    tick();
    r16_val = 1'b0;
    r16_msg = 8'($urandom);
  endtask

  task automatic chunk12(input logic [7:0] b);
    r12_val = 1'b1;
    r12_msg = b;
    tick();
    r12_val = 1'b0;
    r12_msg = 8'($urandom);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    n_tests += 9;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL rst_s16_val: got %b expected 0", s16_val); end
    if (r16_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_r16_rdy: got %b expected 1", r16_rdy); end
    if (s16_msg !== 16'h0) begin n_fail++; $display("FAIL rst_s16_msg: got %h expected 0000", s16_msg); end
    if (s12_val !== 1'b0) begin n_fail++; $display("FAIL rst_s12_val: got %b expected 0", s12_val); end
    if (r12_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_r12_rdy: got %b expected 1", r12_rdy); end
    if (s12_msg !== 12'h0) begin n_fail++; $display("FAIL rst_s12_msg: got %h expected 000", s12_msg); end
    if (s8_val !== 1'b0) begin n_fail++; $display("FAIL rst_s8_val: got %b expected 0", s8_val); end
    if (r8_rdy !== 1'b1) begin n_fail++; $display("FAIL rst_r8_rdy: got %b expected 1", r8_rdy); end
    if (s8_msg !== 8'h0) begin n_fail++; $display("FAIL rst_s8_msg: got %h expected 00", s8_msg); end
  endtask

  task automatic test_basic16();
    s16_rdy = 1'b1;
    chunk16(8'hAB);
    n_tests++;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL basic_mid_val: got %b expected 0", s16_val); end
    exp_q.push_back(16'hABCD);
    chunk16(8'hCD);
    exp = exp_q.pop_front();
    n_tests += 3;
    if (s16_val !== 1'b1) begin n_fail++; $display("FAIL basic_val: got %b expected 1", s16_val); end
    if (s16_msg !== exp) begin n_fail++; $display("FAIL basic_msg: got %h expected %h", s16_msg, exp); end
    if (r16_rdy !== (BYP & s16_rdy)) begin n_fail++; $display("FAIL basic_send_rdy: got %b expected %b", r16_rdy, BYP & s16_rdy); end
    tick();
    n_tests += 2;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL basic_done_val: got %b expected 0", s16_val); end
    if (r16_rdy !== 1'b1) begin n_fail++; $display("FAIL basic_done_rdy: got %b expected 1", r16_rdy); end
    // Junk on recv_msg without recv_val must leave the registers alone.
    r16_msg = 8'h5F;
    tick();
    r16_msg = 8'hE1;
    tick();
    n_tests++;
    if (s16_msg !== 16'hABCD) begin n_fail++; $display("FAIL idle_hold_msg: got %h expected abcd", s16_msg); end
  endtask

  task automatic test_trunc12();
    s12_rdy = 1'b1;
    exp_q.push_back(16'h0ABC);
    chunk12(8'hFA);
    chunk12(8'hBC);
    exp = exp_q.pop_front();
    n_tests += 2;
    if (s12_val !== 1'b1) begin n_fail++; $display("FAIL trunc_val: got %b expected 1", s12_val); end
    if ({4'h0, s12_msg} !== exp) begin n_fail++; $display("FAIL trunc_msg: got %h expected %h", s12_msg, exp); end
    tick();
    n_tests++;
    if (s12_val !== 1'b0) begin n_fail++; $display("FAIL trunc_done_val: got %b expected 0", s12_val); end
  endtask

  task automatic test_hold();
    s16_rdy = 1'b0;
    exp_q.push_back(16'hABCD);
    chunk16(8'hAB);
    chunk16(8'hCD);
    exp = exp_q.pop_front();
    r16_val = 1'b1;
    r16_msg = 8'h99;
    for (int i = 0; i < 5; i++) begin
      n_tests += 3;
      if (s16_val !== 1'b1) begin n_fail++; $display("FAIL hold_val[%0d]: got %b expected 1", i, s16_val); end
      if (s16_msg !== exp) begin n_fail++; $display("FAIL hold_msg[%0d]: got %h expected %h", i, s16_msg, exp); end
      if (r16_rdy !== 1'b0) begin n_fail++; $display("FAIL hold_rdy[%0d]: got %b expected 0", i, r16_rdy); end
      tick();
    end
    r16_val = 1'b0;
    s16_rdy = 1'b1;
    n_tests++;
    if (s16_msg !== exp) begin n_fail++; $display("FAIL hold_final_msg: got %h expected %h", s16_msg, exp); end
    tick();
    n_tests += 2;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL hold_done_val: got %b expected 0", s16_val); end
    if (r16_rdy !== 1'b1) begin n_fail++; $display("FAIL hold_done_rdy: got %b expected 1", r16_rdy); end
  endtask

  task automatic test_reset_mid();
    s16_rdy = 1'b1;
    chunk16(8'hAB);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests += 2;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_val: got %b expected 0", s16_val); end
    if (s16_msg !== 16'h0) begin n_fail++; $display("FAIL rstmid_msg: got %h expected 0000", s16_msg); end
    exp_q.push_back(16'h1234);
    chunk16(8'h12);
    n_tests++;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL rstmid_early_val: got %b expected 0", s16_val); end
    chunk16(8'h34);
    exp = exp_q.pop_front();
    n_tests += 2;
    if (s16_val !== 1'b1) begin n_fail++; $display("FAIL rstmid_pkt_val: got %b expected 1", s16_val); end
    if (s16_msg !== exp) begin n_fail++; $display("FAIL rstmid_pkt_msg: got %h expected %h", s16_msg, exp); end
    // Reset while a packet is held must drop it.
    s16_rdy = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_tests += 2;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL rstsend_val: got %b expected 0", s16_val); end
    if (r16_rdy !== 1'b1) begin n_fail++; $display("FAIL rstsend_rdy: got %b expected 1", r16_rdy); end
  endtask

  task automatic test_single8();
    s8_rdy = 1'b1;
    exp_q.push_back(16'h005A);
    r8_val = 1'b1;
    r8_msg = 8'h5A;
    tick();
    r8_val = 1'b0;
    exp = exp_q.pop_front();
    n_tests += 2;
    if (s8_val !== 1'b1) begin n_fail++; $display("FAIL single_val: got %b expected 1", s8_val); end
    if ({8'h0, s8_msg} !== exp) begin n_fail++; $display("FAIL single_msg: got %h expected %h", s8_msg, exp); end
`ifdef PACKET_ASSEMBLER_BYPASS_EN
    r8_val = 1'b1;
    r8_msg = 8'h77;
    tick();
    r8_val = 1'b0;
    n_tests += 2;
    if (s8_val !== 1'b1) begin n_fail++; $display("FAIL single_byp_val: got %b expected 1", s8_val); end
    if (s8_msg !== 8'h77) begin n_fail++; $display("FAIL single_byp_msg: got %h expected 77", s8_msg); end
`endif
    tick();
    n_tests++;
    if (s8_val !== 1'b0) begin n_fail++; $display("FAIL single_done_val: got %b expected 0", s8_val); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] chunks [6];
    int idx, pkts, last_cyc;
    bit acc;
    chunks = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66};
    exp_q.push_back(16'h1122);
    exp_q.push_back(16'h3344);
    exp_q.push_back(16'h5566);
    idx = 0;
    pkts = 0;
    last_cyc = -1;
    s16_rdy = 1'b1;
    for (int cyc = 0; cyc < 40 && pkts < 3; cyc++) begin
      r16_val = (idx < 6);
      r16_msg = (idx < 6) ? chunks[idx] : 8'h00;
      acc = r16_val & r16_rdy;
      if (s16_val && s16_rdy) begin
        exp = exp_q.pop_front();
        n_tests++;
        if (s16_msg !== exp) begin n_fail++; $display("FAIL b2b_msg[%0d]: got %h expected %h", pkts, s16_msg, exp); end
        pkts++;
        last_cyc = cyc;
      end
      tick();
      if (acc) idx++;
    end
    r16_val = 1'b0;
    n_tests += 2;
    if (pkts !== 3) begin n_fail++; $display("FAIL b2b_count: got %0d expected 3", pkts); end
    if (last_cyc !== (BYP ? 6 : 8)) begin n_fail++; $display("FAIL b2b_timing: got %0d expected %0d", last_cyc, BYP ? 6 : 8); end
    tick();
  endtask

`ifdef PACKET_ASSEMBLER_BYPASS_EN
  task automatic test_bypass();
    s16_rdy = 1'b0;
    exp_q.push_back(16'hABCD);
    exp_q.push_back(16'h1234);
    chunk16(8'hAB);
    chunk16(8'hCD);
    exp = exp_q.pop_front();
    n_tests += 2;
    if (s16_msg !== exp) begin n_fail++; $display("FAIL byp_first_msg: got %h expected %h", s16_msg, exp); end
    if (r16_rdy !== 1'b0) begin n_fail++; $display("FAIL byp_rdy_low: got %b expected 0", r16_rdy); end
    s16_rdy = 1'b1;
    chunk16(8'h12);
    n_tests += 2;
    if (s16_val !== 1'b0) begin n_fail++; $display("FAIL byp_fill_val: got %b expected 0", s16_val); end
    if (r16_rdy !== 1'b1) begin n_fail++; $display("FAIL byp_fill_rdy: got %b expected 1", r16_rdy); end
    chunk16(8'h34);
    exp = exp_q.pop_front();
    n_tests += 2;
    if (s16_val !== 1'b1) begin n_fail++; $display("FAIL byp_second_val: got %b expected 1", s16_val); end
    if (s16_msg !== exp) begin n_fail++; $display("FAIL byp_second_msg: got %h expected %h", s16_msg, exp); end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_basic16();
    test_trunc12();
    test_hold();
    test_reset_mid();
    test_single8();
    test_back_to_back();
`ifdef PACKET_ASSEMBLER_BYPASS_EN
    test_bypass();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/packet_assembler.md
PACKET_ASSEMBLER -- requirements
Module: packet_assembler

Interface
REQ-001 SHALL have parameter nbits_in, default 8: width of each incoming small packet (chunk).
REQ-002 SHALL have parameter nbits_out, default 8: width of the assembled output packet; nbits_out >= nbits_in.
REQ-003 SHALL derive num_regs = ceil(nbits_out/nbits_in) and cnt_bits = $clog2(num_regs)+1; these are not user-set.
REQ-004 SHALL have clk  input  1  sole clock; all state updates on posedge clk.
REQ-005 SHALL have reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have recv_val  input  1  chunk valid.
REQ-007 SHALL have recv_rdy  output  1  block can accept a chunk.
REQ-008 SHALL have recv_msg  input  nbits_in  chunk data.
REQ-009 SHALL have send_val  output  1  assembled packet valid.
REQ-010 SHALL have send_rdy  input  1  downstream accepts packet.
REQ-011 SHALL have send_msg  output  nbits_out  assembled packet.

Function
REQ-012 SHALL transfer a chunk when recv_val & recv_rdy, and a packet when send_val & send_rdy, both in the same cycle.
REQ-013 SHALL treat the first chunk of a packet as most significant; chunk k (0-based) SHALL land in register num_regs-1-k.
REQ-014 SHALL build the top output bits from the low (nbits_out - nbits_in*(num_regs-1)) bits of the first chunk and discard its upper bits.
REQ-015 SHALL use two states: FILL (collecting chunks) and SEND (packet held).
REQ-016 SHALL, in FILL, assert recv_rdy=1 and send_val=0, and increment the chunk counter on each accepted chunk.
REQ-017 SHALL move FILL->SEND on acceptance of chunk num_regs-1 and clear the counter, so send_val rises the cycle after the last chunk is accepted (latency 1).
REQ-018 SHALL, in SEND, hold send_val=1 and send_msg stable until send_rdy=1, then return to FILL.
REQ-019 SHALL drive send_msg as the concatenation of all registers; upper bits that are never written SHALL be 0.
REQ-020 SHALL, when nbits_in == nbits_out (num_regs=1), act as a one-entry buffer: one chunk -> SEND.
REQ-021 SHALL ignore recv_msg whenever no chunk transfer occurs, and SHALL not change registers.

Reset
REQ-022 SHALL on reset force state=FILL, counter=0, send_val=0, recv_rdy=1, all data registers=0.
REQ-023 SHALL on reset mid-fill or mid-send discard the partial or held packet; no packet is emitted for it.

Configuration
REQ-024 SHALL support macro PACKET_ASSEMBLER_BYPASS_EN.
REQ-025 Without PACKET_ASSEMBLER_BYPASS_EN: recv_rdy=0 throughout SEND, so there is at least one idle chunk cycle between packets.
REQ-026 With PACKET_ASSEMBLER_BYPASS_EN: in SEND, recv_rdy=send_rdy. A chunk accepted together with the packet is the first chunk of the next packet, and the next state is FILL with counter=1.
REQ-027 With PACKET_ASSEMBLER_BYPASS_EN and num_regs=1: a simultaneous send and receive keeps the state in SEND with the new data.

Structure
REQ-028 SHALL place the state enum (FILL, SEND) and a num_regs ceiling-divide function in shared package packet_assembler_pkg.
REQ-029 SHALL implement the chunk counter as sub-module packet_assembler_ctr, with clear, increment and a terminal-count output at num_regs-1.

Verification
REQ-030 nbits_in=8, nbits_out=16: chunks 0xAB, 0xCD with send_rdy=1 -> send_val=1 the cycle after 0xCD, send_msg=0xABCD, then FILL.
REQ-031 nbits_in=8, nbits_out=12: chunks 0xFA, 0xBC -> send_msg=0xABC (upper nibble 0xF discarded).
REQ-032 16-bit packet complete, send_rdy=0 for 5 cycles -> send_msg holds 0xABCD, recv_rdy=0 (no macro); send_rdy=1 -> accepted, recv_rdy=1 the next cycle.
REQ-033 Accept 0xAB, then reset, then 0x12, 0x34 -> single packet 0x1234; 0xAB is never emitted.
REQ-034 With PACKET_ASSEMBLER_BYPASS_EN: in SEND(0xABCD), send_rdy=1 with recv_val=1 and chunk 0x12, then 0x34 -> packets 0xABCD, 0x1234 back-to-back with no idle cycle.
REQ-035 nbits_in=nbits_out=8: chunk 0x5A -> send_msg=0x5A with send_val=1 one cycle later.
